// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter:
// the response-owner encoding, the default address width and the error data.
package imem_port_arbiter_pkg;

    // Default word-address width (32-word memory).
    localparam int AW_DEFAULT = 5;

    // Data returned with every error or write-acknowledge response.
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    // Which requester owns the response that is due in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    // A byte address is unusable if it is not word aligned or lies past the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests;
// the pointer remembers which side won most recently.
module rr_arb2 (
    input  logic CLK,
    input  logic RST,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 was granted last, so requester 0 wins the next contention.
    logic last1;

    // Grant the sole requester, or on contention the one not granted last.
    always_comb begin
        gnt0 = req0 && (!req1 || last1);
        gnt1 = req1 && (!req0 || !last1);
    end

    // Track the most recent winner; reset favours requester 0 on first contention.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last1 <= 1'b1;
        end else if (gnt0) begin
            last1 <= 1'b0;
        end else if (gnt1) begin
            last1 <= 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one single-port memory between the
// fetch unit and a loader/debug port. One-cycle, fully pipelined responses.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    input  logic          f_flush,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    logic        f_bad;
    logic        l_bad;
    logic [31:0] sel_addr;
    owner_t      rsp_owner;
    logic        rsp_err;
    logic        rsp_wr;

    // Requests are masked during reset so no grant or memory access can appear.
    rr_arb2 u_arb (
        .CLK  (CLK),
        .RST  (RST),
        .req0 (f_req && !RST),
        .req1 (l_req && !RST),
        .gnt0 (f_gnt),
        .gnt1 (l_gnt)
    );

    // Decode the granted address and drive the memory port for this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        f_bad     = addr_bad(f_addr, AW);
        l_bad     = addr_bad(l_addr, AW);
        sel_addr  = l_gnt ? l_addr : f_addr;
        mem_en    = (f_gnt && !f_bad) || (l_gnt && !l_bad);
        mem_we    = l_gnt && !l_bad && l_we;
        mem_addr  = sel_addr[AW+1:2];
        mem_wdata = l_gnt ? l_wdata : 32'd0;
    end

    // Register the owner and response kind at grant so the response lands one cycle later.
    // NOTE: asynchronous reset drops any in-flight response immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_owner <= OWN_NONE;
            rsp_err   <= 1'b0;
            rsp_wr    <= 1'b0;
        end else begin
            rsp_owner <= f_gnt ? OWN_FETCH : (l_gnt ? OWN_LOAD : OWN_NONE);
            rsp_err   <= f_gnt ? f_bad : (l_gnt && l_bad);
            rsp_wr    <= l_gnt && l_we;
        end
    end

    // Route the response to its owner; the other side sees all zeros.
    always_comb begin
        f_rvalid = (rsp_owner == OWN_FETCH) && !f_flush;
        f_err    = f_rvalid && rsp_err;
        f_rdata  = (f_rvalid && !rsp_err) ? mem_rdata : ERR_RDATA;
        l_rvalid = (rsp_owner == OWN_LOAD);
        l_err    = l_rvalid && rsp_err;
        l_rdata  = (l_rvalid && !rsp_err && !rsp_wr) ? mem_rdata : ERR_RDATA;
    end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter AW, default 5, word-address width; memory depth is 2**AW words (32).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 f_req  input  1  fetch requester read request; held until granted.
REQ-005 f_addr  input  32  fetch byte address (PC).
REQ-006 f_flush  input  1  fetch flush; drops the in-flight fetch response.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch response valid.
REQ-009 f_rdata  output  32  fetch instruction word.
REQ-010 f_err  output  1  fetch response is an error (misaligned or out of range).
REQ-011 l_req  input  1  loader/debug request; held until granted.
REQ-012 l_we  input  1  loader write enable (1 = write, 0 = read).
REQ-013 l_addr  input  32  loader byte address.
REQ-014 l_wdata  input  32  loader write data.
REQ-015 l_gnt  output  1  loader request accepted this cycle.
REQ-016 l_rvalid  output  1  loader response valid (read data or write acknowledge).
REQ-017 l_rdata  output  32  loader read data; 0 for writes and errors.
REQ-018 l_err  output  1  loader response is an error.
REQ-019 mem_en, mem_we  output  1 each  single-port memory enable / write enable.
REQ-020 mem_addr  output  AW  memory word address = granted addr[AW+1:2].
REQ-021 mem_wdata  output  32  memory write data = l_wdata when the loader is granted.
REQ-022 mem_rdata  input  32  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-023 At most one of f_gnt/l_gnt SHALL be high per cycle; grants, mem_en, mem_we, mem_addr and mem_wdata are combinational from the current requests and arbitration state.
REQ-024 Single requester: grant in the same cycle as its req, with no bubble.
REQ-025 Both requesting: round-robin; grant the requester not granted most recently, then update the last-granted pointer on every grant.
REQ-026 Back-to-back grants SHALL be accepted every cycle (fully pipelined, one response per grant, in grant order).
REQ-027 Latency: the response (rvalid, rdata, err) to the granted requester SHALL appear exactly 1 cycle after the grant; the owner and error tag are registered at grant.
REQ-028 Error on addr[1:0]!=0 or addr[31:AW+2]!=0: grant issued, mem_en low, response err=1, rdata=0.
REQ-029 Loader write: mem_en=1, mem_we=1; next cycle l_rvalid=1, l_err=0, l_rdata=0.
REQ-030 Loader write followed by a fetch of the same address in the next cycle SHALL return the new data (grant-order ordering).
REQ-031 f_flush high in the cycle a fetch response is due SHALL force f_rvalid=0; f_flush in the same cycle as f_gnt does not cancel that grant. f_flush has no effect on loader traffic.
REQ-032 Outputs of the requester that is not the response owner SHALL be rvalid=0, rdata=0, err=0.
REQ-033 A requester dropping req before grant is legal; nothing is issued for it.

Reset
REQ-034 While RST is high: all outputs 0, the in-flight response is discarded, and the last-granted pointer is set to loader so fetch wins the first contention.
REQ-035 The first grant SHALL be possible in the first CLK edge cycle after RST deasserts.

Structure
REQ-036 The shared package holds the owner encoding (OWN_NONE, OWN_FETCH, OWN_LOAD), the AW default, and the error response data constant (0).
REQ-037 One sub-module, rr_arb2 (2-way round-robin grant with last-granted pointer); address decode and response routing stay in the top level.

Verification
REQ-038 Reset, then f_req with f_addr=0x00000008 -> f_gnt same cycle, mem_addr=2; next cycle f_rvalid=1 and f_rdata=mem word 2.
REQ-039 f_req and l_req (read 0x0C) held 4 cycles after reset -> grants F,L,F,L; responses alternate, each 1 cycle after its grant.
REQ-040 Loader write 0xDEADCAFE to 0x10, then fetch 0x10 in the next cycle -> l_rvalid with l_rdata=0, then f_rdata=0xDEADCAFE.
REQ-041 f_addr=0x00000082 and then f_addr=0x00000080 -> mem_en=0, f_err=1, f_rdata=0 for both.
REQ-042 Fetch granted, f_flush=1 in the next cycle -> f_rvalid=0; RST pulsed with a response in flight -> no rvalid and all outputs 0.
